// File: rtl/bobatc_pkg.sv
// Shared constants for the UART receive path.
package bobatc_pkg;

    localparam int UART_WORD_W = 9;

endpackage

// File: rtl/uart_rx_buffer_mem.sv
// Word storage for uart_rx_buffer: synchronous write port, combinational read port.
module uart_rx_buffer_mem
    import bobatc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_WORD_W
) (
    input  logic                     clock,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset on the array: contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_buffer.sv
// FWFT receive buffer behind the UART receiver, with sticky overflow/framing flags
// and a saturating framing-error counter.
module uart_rx_buffer
    import bobatc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_WORD_W,
    parameter int ERR_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     rx_framing_error,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frame_error,
    output logic [ERR_W-1:0]         err_count,
    input  logic                     clear_errors
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             frame_error_q, frame_error_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fe_prev_q;

    logic full;
    logic push;
    logic pop;
    logic drop;
    logic fe_event;

    assign full     = (count_q == FULL_COUNT);
    assign pop      = out_valid && out_ready;
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign push     = rx_done && (!full || pop) && !reset;
    assign drop     = rx_done && full && !pop;
    assign fe_event = rx_framing_error && !fe_prev_q;

    uart_rx_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (rx_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data)
    );

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        frame_error_d = frame_error_q;
        err_count_d   = err_count_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // A new event in the same cycle as a clear takes priority over the clear.
        if (clear_errors) begin
            overflow_d    = 1'b0;
            frame_error_d = 1'b0;
            err_count_d   = '0;
        end
        if (drop) overflow_d = 1'b1;
        if (fe_event) begin
            frame_error_d = 1'b1;
            if (clear_errors)        err_count_d = ERR_W'(1);
            else if (!(&err_count_q)) err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
            err_count_q   <= '0;
            fe_prev_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
            err_count_q   <= err_count_d;
            fe_prev_q     <= rx_framing_error;
        end
    end

    assign out_valid   = (count_q != '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer sitting directly downstream of the UART receiver. It captures each 9-bit word the receiver reports as done into a first-word-fall-through FIFO and presents it to the command decoder through a valid/ready handshake. It also records receiver framing errors and buffer overflows in sticky flags plus a saturating error counter.

## Interface
Parameters:
- DEPTH, 8, number of word slots; power of two, ≥ 2
- WIDTH, 9, word width; matches the receiver data width
- ERR_W, 8, width of the framing-error counter

Ports:
- clock  input  1  sole clock; all state updates on posedge
- reset  input  1  one clock; reset is synchronous and active-high
- rx_data  input  WIDTH  word from receiver; sampled only when rx_done=1
- rx_done  input  1  one-cycle pulse: rx_data holds a complete word
- rx_framing_error  input  1  level; high while receiver is in its framing-error state
- out_data  output  WIDTH  head-of-FIFO word; meaningful only when out_valid=1
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head word when out_valid && out_ready
- count  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH
- overflow  output  1  sticky: a word was dropped because the FIFO was full
- frame_error  output  1  sticky: at least one framing error occurred
- err_count  output  ERR_W  framing-error events, saturating at all-ones
- clear_errors  input  1  one-cycle request to clear overflow, frame_error, err_count

## Operation
- Storage: DEPTH × WIDTH array; write pointer wr_ptr and read pointer rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is held as a separate register.
- push = rx_done && (count < DEPTH || pop); pop = out_valid && out_ready.
- A push writes rx_data at wr_ptr and increments wr_ptr. A pop increments rd_ptr.
- count updates as follows: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- Full with simultaneous rx_done and pop: both are accepted and count stays DEPTH.
- Full with rx_done and no pop: the word is dropped, pointers and count do not change, and overflow is set.
- Empty: out_valid=0 and out_ready is ignored. A push into an empty FIFO does not pop in the same cycle.
- out_data = mem[rd_ptr] (combinational read, FWFT). out_valid = (count != 0).
- Framing error event = rising edge of rx_framing_error, detected with a one-cycle delayed copy. Each event sets frame_error and increments err_count unless err_count is already all-ones.
- clear_errors clears overflow, frame_error and err_count. If a new overflow or framing event occurs in the same cycle, the event wins: the flag is set and err_count becomes 1, or stays at 0 for an overflow-only event.
- The buffer never modifies or reorders data; word order out equals word order in.

## Timing
- Reset: pointers=0, count=0, out_valid=0, overflow=0, frame_error=0, err_count=0, edge-detect register=0. out_data is don't-care.
- Reset asserted mid-operation discards all stored words at the next edge. rx_done in that same cycle is ignored.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N, so it is accepted no earlier than edge N+1.
- Pop takes effect at the edge where out_valid && out_ready; the next word (or out_valid=0) is visible after that edge.
- Sticky flags and err_count update at the same edge as the triggering event.
- A framing error whose level stays high for multiple cycles counts once; each new rising edge counts again.

## Structure
- The shared package (bobatc_pkg) holds the constant UART_WORD_W = 9; WIDTH defaults to it.
- Pointer, count and flag logic live in uart_rx_buffer.
- The storage array with its synchronous write port and combinational read port is one natural sub-module, uart_rx_buffer_mem (parameters DEPTH, WIDTH).
- No FSM beyond the pointer/count registers and the framing-error edge detector.

## Test plan
- Fill/drain, DEPTH=8: push 0x101, 0x002…0x008 with out_ready=0 -> count=8, out_data=0x101. Then out_ready=1 for 8 cycles -> words emerge in order, count reaches 0, out_valid=0.
- Overflow: with the FIFO full, pulse rx_done with 0x1FF -> word absent from the output stream, count=8, overflow=1. Then clear_errors -> overflow=0.
- Simultaneous push/pop at full: count=8, rx_done with 0x0AA and out_ready=1 in the same cycle -> head popped, count stays 8, overflow=0, 0x0AA is the last word out.
- Empty push: count=0, rx_done with 0x155 and out_ready=1 -> next cycle out_valid=1, out_data=0x155, count=1.
- Framing errors: hold rx_framing_error high 5 cycles, low, then high 1 cycle -> err_count=2, frame_error=1. Force 300 edges with ERR_W=8 -> err_count=255. clear_errors coinciding with an edge -> err_count=1.
- Reset mid-operation: 3 words stored, assert reset 1 cycle with rx_done=1 -> count=0, out_valid=0, all flags 0. Next push appears as the sole word.
